// File: rtl/imem_responder_if.sv
// ============================================================================
// Module      : imem_responder_if
// Description : Word-serial fetch request/response bus between the fetch
//               controller (master) and the instruction-memory responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface imem_responder_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_rdata;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_req_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_req_rdata
    );
endinterface

`default_nettype wire

// File: rtl/imem_responder.sv
// ============================================================================
// Module      : imem_responder
// Description : Instruction-memory responder; serves one word per request
//               after LATENCY cycles, with preload port and access counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_responder #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    imem_responder_if.slave    bus,
    input  wire logic          init_we,
    input  wire logic [31:0]   init_addr,
    input  wire logic [31:0]   init_wdata,
    output logic               busy,
    output logic [31:0]        req_count
);

    localparam int         c_aw     = $clog2(DEPTH);
    localparam logic [7:0] c_lat_m1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_next;
    logic [c_aw-1:0] r_idx;
    logic [c_aw-1:0] w_idx_next;
    logic [c_aw-1:0] w_req_idx;
    logic [c_aw-1:0] w_init_idx;
    logic            r_ready;
    logic [31:0]     r_rdata;
    logic [31:0]     r_req_count;
    logic [31:0]     r_mem [DEPTH];
    logic            unused_addr_bits;

    assign w_req_idx  = bus.mem_req_addr[c_aw+1:2];
    assign w_init_idx = init_addr[c_aw+1:2];

    // Upper address bits alias and byte-offset bits are don't-care.
    assign unused_addr_bits = ^{bus.mem_req_addr[31:c_aw+2], bus.mem_req_addr[1:0],
                                init_addr[31:c_aw+2], init_addr[1:0]};

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_idx_next = r_idx;
        case (r_state)
            IDLE: begin
                if (bus.mem_req_valid) begin
                    w_idx_next = w_req_idx;
                    if (LATENCY == 1) begin
                        w_next = RESP;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = c_lat_m1;
                    end
                end
            end
            WAIT: begin
                if (!bus.mem_req_valid) begin
                    w_next = IDLE;
                end else if (r_cnt == 8'd1) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            RESP:    w_next = GAP;
            GAP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // w_idx_next already selects the live address when entering RESP straight from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_idx       <= '0;
            r_ready     <= 1'b0;
            r_rdata     <= 32'd0;
            r_req_count <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_ready <= (w_next == RESP);
            if ((w_next == RESP) && (r_state != RESP)) begin
                r_rdata <= r_mem[w_idx_next];
            end
            if (r_state == RESP) begin
                r_req_count <= r_req_count + 32'd1;
            end
        end
    end

    // Array has no reset; a same-edge preload leaves the outgoing read with old data.
    always_ff @(posedge clk) begin
        if (init_we) begin
            r_mem[w_init_idx] <= init_wdata;
        end
    end

    assign bus.mem_req_ready = r_ready;
    assign bus.mem_req_rdata = r_rdata;
    assign busy              = (r_state != IDLE);
    assign req_count         = r_req_count;

endmodule

`default_nettype wire
